vliw_fetch_unit: RTL and testbench

- Parametrised VLIW fetch stage. Generalises a fixed 2-slot, 16-bit, single-cycle-memory IF stage to SLOTS issue slots with variable-latency instruction memory.
- Issues bundle-aligned fetch requests and buffers returned bundles in a FIFO.
- Applies exception/jump/branch redirects with squashing of stale in-flight responses.
- Delivers bundles to decode through a valid/ready handshake, which replaces the simple pipeline-register write enable.

---
 rtl/vliw_fetch_unit.sv | 197 +++++++++++++++++++
 tb/tb_vliw_fetch_unit.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vliw_fetch_unit.sv
// VLIW fetch: bundle-aligned requests, credit-limited to FIFO space, responses buffered in order.
// Latency: request fire at t, response at t+k, bundle_valid at t+k+1; a redirect issues its first new request one cycle later.
// Backpressure: bundle_ready low holds the head bundle; requests stop once FIFO count plus in-flight reaches depth.
// Optional statistics outputs are compiled in with VLIW_FETCH_STATS_EN.

module vliw_fetch_fifo #(
    parameter int  W     = 32,
    parameter int  DEPTH = 4,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;
endmodule

module vliw_fetch_unit #(
    parameter int          SLOTS      = 2,
    parameter int          INSTR_W    = 16,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] PC_RESET   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fetch_en,
    input  logic                     redirect_exc,
    input  logic                     redirect_jump,
    input  logic [31:0]              jump_target,
    input  logic                     redirect_branch,
    input  logic [31:0]              branch_target,
    output logic                     imem_req_valid,
    input  logic                     imem_req_ready,
    output logic [31:0]              imem_addr,
    input  logic                     imem_rsp_valid,
    input  logic [SLOTS*INSTR_W-1:0] imem_rsp_data,
    output logic                     bundle_valid,
    input  logic                     bundle_ready,
    output logic [SLOTS*INSTR_W-1:0] bundle_instr,
    output logic [31:0]              bundle_pc
`ifdef VLIW_FETCH_STATS_EN
    ,
    output logic [31:0]              stat_bundles,
    output logic [31:0]              stat_redirects,
    output logic [31:0]              stat_dropped
`endif
);
    localparam int          DW           = SLOTS * INSTR_W;
    localparam logic [31:0] BUNDLE_BYTES = 32'(DW / 8);
    localparam int          CW           = $clog2(FIFO_DEPTH + 1);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   head_pc_q, head_pc_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] count;
    logic          redirect_any;
    logic [31:0]   target;
    logic          req_ok, req_fire;
    logic          rsp_discard, push, pop;

    assign redirect_any = redirect_exc | redirect_jump | redirect_branch;
    assign target       = redirect_exc  ? EXC_VECTOR  :
                          redirect_jump ? jump_target : branch_target;

    // Credit rule: every accepted request already owns a FIFO slot.
    assign req_ok   = fetch_en & ~redirect_any &
                      (({1'b0, count} + {1'b0, inflight_q}) < (CW+1)'(FIFO_DEPTH));
    assign req_fire = req_ok & imem_req_ready;

    assign rsp_discard = imem_rsp_valid & (redirect_any | (drop_q != '0));
    assign push        = imem_rsp_valid & ~rsp_discard;
    assign pop         = bundle_valid & bundle_ready;

    vliw_fetch_fifo #(.W(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect_any),
        .din   (imem_rsp_data),
        .dout  (bundle_instr),
        .count (count)
    );

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        head_pc_d  = head_pc_q;
        inflight_d = inflight_q + CW'(req_fire) - CW'(imem_rsp_valid);
        drop_d     = drop_q;
        if (redirect_any) begin
            fetch_pc_d = target;
            head_pc_d  = target;
            // Everything still outstanding after this edge belongs to the old stream.
            drop_d     = inflight_q - CW'(imem_rsp_valid);
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + BUNDLE_BYTES;
            if (pop)      head_pc_d  = head_pc_q + BUNDLE_BYTES;
            if (rsp_discard) drop_d = drop_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= PC_RESET;
            head_pc_q  <= PC_RESET;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            head_pc_q  <= head_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    // The reset term keeps the request quiet even if fetch_en is high during reset.
    assign imem_req_valid = req_ok & reset;
    assign imem_addr      = fetch_pc_q;
    assign bundle_valid   = (count != '0) & ~redirect_any;
    assign bundle_pc      = head_pc_q;

`ifdef VLIW_FETCH_STATS_EN
    logic [31:0] stat_bundles_q, stat_bundles_d;
    logic [31:0] stat_redirects_q, stat_redirects_d;
    logic [31:0] stat_dropped_q, stat_dropped_d;

    always_comb begin
        stat_bundles_d   = stat_bundles_q;
        stat_redirects_d = stat_redirects_q;
        stat_dropped_d   = stat_dropped_q;
        if (pop && stat_bundles_q != '1)            stat_bundles_d   = stat_bundles_q + 32'd1;
        if (redirect_any && stat_redirects_q != '1) stat_redirects_d = stat_redirects_q + 32'd1;
        if (rsp_discard && stat_dropped_q != '1)    stat_dropped_d   = stat_dropped_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_bundles_q   <= '0;
            stat_redirects_q <= '0;
            stat_dropped_q   <= '0;
        end else begin
            stat_bundles_q   <= stat_bundles_d;
            stat_redirects_q <= stat_redirects_d;
            stat_dropped_q   <= stat_dropped_d;
        end
    end

    assign stat_bundles   = stat_bundles_q;
    assign stat_redirects = stat_redirects_q;
    assign stat_dropped   = stat_dropped_q;
`endif
endmodule

// File: tb/tb_vliw_fetch_unit.sv
// Bench for vliw_fetch_unit: default instance driven by an in-order latency memory model,
// plus a wide instance (4x32-bit, depth 8) driven by hand for step, wrap and push/pop-same-cycle.
module tb_vliw_fetch_unit;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   lat = 1;
    int unsigned cyc = 0;

    always #5 clk = ~clk;

    // Default instance (SLOTS=2, INSTR_W=16, FIFO_DEPTH=4)
    logic        a_fetch_en = 0, a_redirect_exc = 0, a_redirect_jump = 0, a_redirect_branch = 0;
    logic [31:0] a_jump_target = 0, a_branch_target = 0;
    logic        a_req_valid, a_req_ready = 1'b1;
    logic [31:0] a_addr;
    logic        a_rsp_valid = 0;
    logic [31:0] a_rsp_data = 0;
    logic        a_bundle_valid, a_bundle_ready = 0;
    logic [31:0] a_bundle_instr, a_bundle_pc;
`ifdef VLIW_FETCH_STATS_EN
    logic [31:0] a_stat_bundles, a_stat_redirects, a_stat_dropped;
    logic [31:0] b_stat_bundles, b_stat_redirects, b_stat_dropped;
`endif

    vliw_fetch_unit u_a (
        .clk(clk), .reset(reset), .fetch_en(a_fetch_en),
        .redirect_exc(a_redirect_exc), .redirect_jump(a_redirect_jump), .jump_target(a_jump_target),
        .redirect_branch(a_redirect_branch), .branch_target(a_branch_target),
        .imem_req_valid(a_req_valid), .imem_req_ready(a_req_ready), .imem_addr(a_addr),
        .imem_rsp_valid(a_rsp_valid), .imem_rsp_data(a_rsp_data),
        .bundle_valid(a_bundle_valid), .bundle_ready(a_bundle_ready),
        .bundle_instr(a_bundle_instr), .bundle_pc(a_bundle_pc)
`ifdef VLIW_FETCH_STATS_EN
        , .stat_bundles(a_stat_bundles), .stat_redirects(a_stat_redirects), .stat_dropped(a_stat_dropped)
`endif
    );

    // Wide instance
    logic         b_fetch_en = 0, b_redirect_exc = 0, b_redirect_jump = 0, b_redirect_branch = 0;
    logic [31:0]  b_jump_target = 0, b_branch_target = 0;
    logic         b_req_valid, b_req_ready = 1'b1;
    logic [31:0]  b_addr;
    logic         b_rsp_valid = 0;
    logic [127:0] b_rsp_data = 0;
    logic         b_bundle_valid, b_bundle_ready = 0;
    logic [127:0] b_bundle_instr;
    logic [31:0]  b_bundle_pc;

    vliw_fetch_unit #(.SLOTS(4), .INSTR_W(32), .FIFO_DEPTH(8)) u_b (
        .clk(clk), .reset(reset), .fetch_en(b_fetch_en),
        .redirect_exc(b_redirect_exc), .redirect_jump(b_redirect_jump), .jump_target(b_jump_target),
        .redirect_branch(b_redirect_branch), .branch_target(b_branch_target),
        .imem_req_valid(b_req_valid), .imem_req_ready(b_req_ready), .imem_addr(b_addr),
        .imem_rsp_valid(b_rsp_valid), .imem_rsp_data(b_rsp_data),
        .bundle_valid(b_bundle_valid), .bundle_ready(b_bundle_ready),
        .bundle_instr(b_bundle_instr), .bundle_pc(b_bundle_pc)
`ifdef VLIW_FETCH_STATS_EN
        , .stat_bundles(b_stat_bundles), .stat_redirects(b_stat_redirects), .stat_dropped(b_stat_dropped)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[15:0]};
    endfunction

    // In-order memory for instance A: a request fired in cycle t answers in cycle t+lat.
    logic [31:0] addr_q[$];
    int unsigned due_q[$];

    always @(posedge clk) begin
        if (a_req_valid && a_req_ready) begin
            addr_q.push_back(a_addr);
            due_q.push_back(cyc + lat);
        end
        if (a_rsp_valid && addr_q.size() > 0) begin
            void'(addr_q.pop_front());
            void'(due_q.pop_front());
        end
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        a_rsp_valid = 1'b0;
        a_rsp_data  = '0;
        if (addr_q.size() > 0 && due_q[0] <= cyc) begin
            a_rsp_valid = 1'b1;
            a_rsp_data  = mem_word(addr_q[0]);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        a_fetch_en = 0; a_redirect_exc = 0; a_redirect_jump = 0; a_redirect_branch = 0; a_bundle_ready = 0;
        b_fetch_en = 0; b_redirect_exc = 0; b_redirect_jump = 0; b_redirect_branch = 0; b_bundle_ready = 0;
        b_rsp_valid = 0;
        addr_q.delete();
        due_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        a_fetch_en = 1'b1;
        b_fetch_en = 1'b1;
        #1;
        checks++; if (a_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got=%b exp=0", a_req_valid); end
        checks++; if (a_bundle_valid !== 1'b0) begin errors++; $display("FAIL reset_bundle_valid got=%b exp=0", a_bundle_valid); end
        checks++; if (a_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", a_addr); end
        checks++; if (a_bundle_pc !== 32'h0) begin errors++; $display("FAIL reset_bundle_pc got=%h exp=0", a_bundle_pc); end
        checks++; if (b_req_valid !== 1'b0 || b_addr !== 32'h0) begin errors++; $display("FAIL reset_b got=%b/%h exp=0/0", b_req_valid, b_addr); end
        do_reset();
    endtask

    task automatic test_straight_line();
        logic [31:0] exp_req, exp_pc;
        int pops;
        lat = 1;
        do_reset();
        a_bundle_ready = 1'b1;
        a_fetch_en = 1'b1;
        exp_req = 32'h0; exp_pc = 32'h0; pops = 0;
        for (int i = 0; i < 14; i++) begin
            #1;
            if (a_req_valid) begin
                checks++; if (a_addr !== exp_req) begin errors++; $display("FAIL line_req_addr got=%h exp=%h", a_addr, exp_req); end
                exp_req = exp_req + 32'd4;
            end
            if (a_bundle_valid) begin
                checks++;
                if (a_bundle_pc !== exp_pc || a_bundle_instr !== mem_word(exp_pc)) begin
                    errors++; $display("FAIL line_bundle got=%h/%h exp=%h/%h", a_bundle_pc, a_bundle_instr, exp_pc, mem_word(exp_pc));
                end
                exp_pc = exp_pc + 32'd4; pops++;
            end
            @(negedge clk);
        end
        checks++; if (pops < 10) begin errors++; $display("FAIL line_pop_count got=%0d exp>=10", pops); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_pc;
        int fires, pops;
        lat = 1;
        do_reset();
        a_fetch_en = 1'b1;
        fires = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (a_req_valid) fires++;
            @(negedge clk);
        end
        #1;
        checks++; if (fires != 4) begin errors++; $display("FAIL bp_fires got=%0d exp=4", fires); end
        checks++; if (a_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_stopped got=%b exp=0", a_req_valid); end
        checks++; if (a_bundle_valid !== 1'b1 || a_bundle_pc !== 32'h0) begin errors++; $display("FAIL bp_head_hold got=%b/%h exp=1/0", a_bundle_valid, a_bundle_pc); end
        a_bundle_ready = 1'b1;
        exp_pc = 32'h0; pops = 0;
        for (int i = 0; i < 20; i++) begin
            if (a_bundle_valid) begin
                checks++;
                if (a_bundle_pc !== exp_pc || a_bundle_instr !== mem_word(exp_pc)) begin
                    errors++; $display("FAIL bp_order got=%h/%h exp=%h/%h", a_bundle_pc, a_bundle_instr, exp_pc, mem_word(exp_pc));
                end
                exp_pc = exp_pc + 32'd4; pops++;
            end
            @(negedge clk); #1;
        end
        checks++; if (pops < 16) begin errors++; $display("FAIL bp_pop_count got=%0d exp>=16", pops); end
    endtask

    task automatic test_redirect_inflight();
        logic [31:0] exp_pc;
        int pops;
        lat = 3;
        do_reset();
        a_bundle_ready = 1'b1;
        a_fetch_en = 1'b1;
        repeat (3) @(negedge clk);
        a_redirect_jump = 1'b1; a_jump_target = 32'h100;
        #1;
        checks++; if (a_req_valid !== 1'b0 || a_bundle_valid !== 1'b0) begin errors++; $display("FAIL redir_cycle got=%b/%b exp=0/0", a_req_valid, a_bundle_valid); end
        @(negedge clk);
        a_redirect_jump = 1'b0;
        #1;
        checks++; if (a_req_valid !== 1'b1 || a_addr !== 32'h100) begin errors++; $display("FAIL redir_new_req got=%b/%h exp=1/100", a_req_valid, a_addr); end
        exp_pc = 32'h100; pops = 0;
        for (int i = 0; i < 20; i++) begin
            if (a_bundle_valid) begin
                checks++;
                if (a_bundle_pc !== exp_pc || a_bundle_instr !== mem_word(exp_pc)) begin
                    errors++; $display("FAIL redir_bundle got=%h/%h exp=%h/%h", a_bundle_pc, a_bundle_instr, exp_pc, mem_word(exp_pc));
                end
                exp_pc = exp_pc + 32'd4; pops++;
            end
            @(negedge clk); #1;
        end
        checks++; if (pops < 3) begin errors++; $display("FAIL redir_pop_count got=%0d exp>=3", pops); end
    endtask

    task automatic test_simultaneous_redirect();
        logic found;
        lat = 1;
        do_reset();
        a_fetch_en = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        checks++; if (a_bundle_valid !== 1'b1) begin errors++; $display("FAIL simul_pre_valid got=%b exp=1", a_bundle_valid); end
        a_redirect_exc = 1'b1;
        a_redirect_jump = 1'b1;   a_jump_target = 32'h200;
        a_redirect_branch = 1'b1; a_branch_target = 32'h300;
        #1;
        checks++; if (a_bundle_valid !== 1'b0 || a_req_valid !== 1'b0) begin errors++; $display("FAIL simul_cycle got=%b/%b exp=0/0", a_bundle_valid, a_req_valid); end
        @(negedge clk);
        a_redirect_exc = 1'b0; a_redirect_jump = 1'b0; a_redirect_branch = 1'b0;
        #1;
        checks++; if (a_req_valid !== 1'b1 || a_addr !== 32'h80) begin errors++; $display("FAIL simul_target got=%b/%h exp=1/80", a_req_valid, a_addr); end
        checks++; if (a_bundle_valid !== 1'b0) begin errors++; $display("FAIL simul_flushed got=%b exp=0", a_bundle_valid); end
        a_bundle_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk); #1;
            if (a_bundle_valid) begin
                found = 1'b1;
                checks++;
                if (a_bundle_pc !== 32'h80 || a_bundle_instr !== mem_word(32'h80)) begin
                    errors++; $display("FAIL simul_first got=%h/%h exp=80/%h", a_bundle_pc, a_bundle_instr, mem_word(32'h80));
                end
            end
        end
        checks++; if (!found) begin errors++; $display("FAIL simul_timeout got=none exp=bundle"); end
    endtask

    task automatic test_reset_midop();
        lat = 1;
        do_reset();
        a_fetch_en = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        checks++; if (a_bundle_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre got=%b exp=1", a_bundle_valid); end
        reset = 1'b0;
        #1;
        checks++; if (a_bundle_valid !== 1'b0 || a_req_valid !== 1'b0) begin errors++; $display("FAIL midrst_valids got=%b/%b exp=0/0", a_bundle_valid, a_req_valid); end
        checks++; if (a_addr !== 32'h0 || a_bundle_pc !== 32'h0) begin errors++; $display("FAIL midrst_pcs got=%h/%h exp=0/0", a_addr, a_bundle_pc); end
        addr_q.delete();
        due_q.delete();
        do_reset();
    endtask

    task automatic test_wide_params();
        logic [127:0] d0, d1, d2;
        d0 = 128'h0000_0003_0000_0002_0000_0001_0000_0000;
        d1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        d2 = 128'hDEAD_BEEF_CAFE_F00D_0123_4567_89AB_CDEF;
        do_reset();
        b_fetch_en = 1'b1;
        b_redirect_jump = 1'b1; b_jump_target = 32'hFFFF_FFF0;
        #1;
        checks++; if (b_req_valid !== 1'b0) begin errors++; $display("FAIL wide_redir_req got=%b exp=0", b_req_valid); end
        @(negedge clk); b_redirect_jump = 1'b0; #1;
        checks++; if (b_req_valid !== 1'b1 || b_addr !== 32'hFFFF_FFF0) begin errors++; $display("FAIL wide_addr0 got=%b/%h exp=1/fffffff0", b_req_valid, b_addr); end
        @(negedge clk); #1;
        checks++; if (b_addr !== 32'h0) begin errors++; $display("FAIL wide_wrap got=%h exp=0", b_addr); end
        @(negedge clk); #1;
        checks++; if (b_addr !== 32'h10) begin errors++; $display("FAIL wide_step got=%h exp=10", b_addr); end
        @(negedge clk); b_fetch_en = 1'b0; #1;
        checks++; if (b_req_valid !== 1'b0) begin errors++; $display("FAIL wide_hold got=%b exp=0", b_req_valid); end
        b_rsp_valid = 1'b1; b_rsp_data = d0;
        #1;
        checks++; if (b_bundle_valid !== 1'b0) begin errors++; $display("FAIL wide_empty got=%b exp=0", b_bundle_valid); end
        @(negedge clk); b_rsp_data = d1; b_bundle_ready = 1'b1; #1;
        checks++; if (b_bundle_valid !== 1'b1 || b_bundle_pc !== 32'hFFFF_FFF0 || b_bundle_instr !== d0) begin
            errors++; $display("FAIL wide_b0 got=%b/%h/%h exp=1/fffffff0/%h", b_bundle_valid, b_bundle_pc, b_bundle_instr, d0); end
        @(negedge clk); b_rsp_data = d2; #1;
        checks++; if (b_bundle_valid !== 1'b1 || b_bundle_pc !== 32'h0 || b_bundle_instr !== d1) begin
            errors++; $display("FAIL wide_b1 got=%b/%h/%h exp=1/0/%h", b_bundle_valid, b_bundle_pc, b_bundle_instr, d1); end
        @(negedge clk); b_rsp_valid = 1'b0; #1;
        checks++; if (b_bundle_valid !== 1'b1 || b_bundle_pc !== 32'h10 || b_bundle_instr !== d2) begin
            errors++; $display("FAIL wide_b2 got=%b/%h/%h exp=1/10/%h", b_bundle_valid, b_bundle_pc, b_bundle_instr, d2); end
        @(negedge clk); #1;
        checks++; if (b_bundle_valid !== 1'b0) begin errors++; $display("FAIL wide_drained got=%b exp=0", b_bundle_valid); end
        b_bundle_ready = 1'b0;
    endtask

`ifdef VLIW_FETCH_STATS_EN
    task automatic test_stats();
        int pops;
        lat = 3;
        do_reset();
        #1;
        checks++; if (a_stat_bundles !== 0 || a_stat_redirects !== 0 || a_stat_dropped !== 0) begin
            errors++; $display("FAIL stats_reset got=%0d/%0d/%0d exp=0/0/0", a_stat_bundles, a_stat_redirects, a_stat_dropped); end
        a_fetch_en = 1'b1;
        repeat (3) @(negedge clk);
        a_redirect_jump = 1'b1; a_jump_target = 32'h100;
        @(negedge clk);
        a_redirect_jump = 1'b0;
        pops = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            a_bundle_ready = a_bundle_valid && (pops < 5);
            if (a_bundle_ready) pops++;
            @(negedge clk);
        end
        a_bundle_ready = 1'b0;
        a_fetch_en = 1'b0;
        repeat (8) @(negedge clk);
        a_redirect_branch = 1'b1; a_branch_target = 32'h300;
        @(negedge clk);
        a_redirect_branch = 1'b0;
        #1;
        checks++; if (a_stat_bundles !== 32'd5) begin errors++; $display("FAIL stats_bundles got=%0d exp=5", a_stat_bundles); end
        checks++; if (a_stat_redirects !== 32'd2) begin errors++; $display("FAIL stats_redirects got=%0d exp=2", a_stat_redirects); end
        checks++; if (a_stat_dropped !== 32'd3) begin errors++; $display("FAIL stats_dropped got=%0d exp=3", a_stat_dropped); end
    endtask
`endif

    initial begin
        test_reset();
        test_straight_line();
        test_backpressure();
        test_redirect_inflight();
        test_simultaneous_redirect();
        test_reset_midop();
        test_wide_params();
`ifdef VLIW_FETCH_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
